// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command arbiter: FSM states, default hold-off
// times, command field positions and the long-execution opcode decode.
package lcd_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_TX = 2'd2,
      DELAY   = 2'd3
   } state_e;

   localparam int WAIT_SHORT_DEF = 2000;
   localparam int WAIT_LONG_DEF  = 82000;

   localparam int DB_RS = 9;
   localparam int DB_RW = 8;

   localparam logic [7:0] CLEAR = 8'h01;
   localparam logic [7:0] HOME  = 8'h02;

   // Clear Display (0x01) and Return Home (0x02/0x03, bit 0 is don't-care)
   // are the only instructions needing the long execution time.
   function automatic logic is_long_cmd(input logic [9:0] db);
      return !db[DB_RS] && !db[DB_RW] &&
             ((db[7:0] == CLEAR) || ((db[7:0] & 8'hFE) == HOME));
   endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Load-and-count-down hold-off timer; counts toward zero and stops there.
module lcd_delay_timer #(
   parameter int CNT_W = 17
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_cmd_arbiter.sv
// Two-port arbiter in front of the LCD transmitter, adding HD44780 hold-off.
// Define LCD_RR_ARB_EN for round-robin arbitration; default is fixed priority to port 0.
module lcd_cmd_arbiter
   import lcd_pkg::*;
#(
   parameter int WAIT_SHORT = WAIT_SHORT_DEF,
   parameter int WAIT_LONG  = WAIT_LONG_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic [9:0] db0,
   input  logic       req1,
   input  logic [9:0] db1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done0,
   output logic       done1,
   output logic       tx_start,
   output logic [9:0] tx_db,
   input  logic       tx_done,
   output logic       busy
);

   localparam int CNT_W = $clog2(WAIT_LONG + 1);
   localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(WAIT_SHORT - 1);
   localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(WAIT_LONG - 1);

   state_e           state_q, state_d;
   logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic             done0_q, done0_d, done1_q, done1_d;
   logic             tx_start_q, tx_start_d;
   logic             busy_q, busy_d;
   logic [9:0]       tx_db_q, tx_db_d;
   logic             owner_q, owner_d;
   logic             win1;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_zero;

`ifdef LCD_RR_ARB_EN
   logic last_q, last_d;
   // On contention the port that did not win last time gets the grant.
   assign win1 = req1 && (!req0 || !last_q);
`else
   assign win1 = req1 && !req0;
`endif

   always_comb begin
      state_d    = state_q;
      gnt0_d     = 1'b0;
      gnt1_d     = 1'b0;
      done0_d    = 1'b0;
      done1_d    = 1'b0;
      tx_start_d = 1'b0;
      busy_d     = busy_q;
      tx_db_d    = tx_db_q;
      owner_d    = owner_q;
      tmr_load   = 1'b0;
      tmr_val    = SHORT_LD;
`ifdef LCD_RR_ARB_EN
      last_d     = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               gnt0_d  = !win1;
               gnt1_d  = win1;
               tx_db_d = win1 ? db1 : db0;
               owner_d = win1;
               busy_d  = 1'b1;
`ifdef LCD_RR_ARB_EN
               last_d  = win1;
`endif
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            tx_start_d = 1'b1;
            state_d    = WAIT_TX;
         end
         WAIT_TX: begin
            if (tx_done) begin
               tmr_load = 1'b1;
               tmr_val  = is_long_cmd(tx_db_q) ? LONG_LD : SHORT_LD;
               state_d  = DELAY;
            end
         end
         DELAY: begin
            if (tmr_zero) begin
               done0_d = !owner_q;
               done1_d = owner_q;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
         done0_q    <= 1'b0;
         done1_q    <= 1'b0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         tx_db_q    <= '0;
         owner_q    <= 1'b0;
`ifdef LCD_RR_ARB_EN
         last_q     <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         gnt0_q     <= gnt0_d;
         gnt1_q     <= gnt1_d;
         done0_q    <= done0_d;
         done1_q    <= done1_d;
         tx_start_q <= tx_start_d;
         busy_q     <= busy_d;
         tx_db_q    <= tx_db_d;
         owner_q    <= owner_d;
`ifdef LCD_RR_ARB_EN
         last_q     <= last_d;
`endif
      end
   end

   lcd_delay_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .load    (tmr_load),
      .load_val(tmr_val),
      .zero    (tmr_zero)
   );

   assign gnt0     = gnt0_q;
   assign gnt1     = gnt1_q;
   assign done0    = done0_q;
   assign done1    = done1_q;
   assign tx_start = tx_start_q;
   assign tx_db    = tx_db_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Directed bench for lcd_cmd_arbiter with shortened hold-off times.
module tb_lcd_cmd_arbiter;

   localparam int WS = 12;
   localparam int WL = 40;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0, req1, tx_done;
   logic [9:0] db0, db1;
   logic       gnt0, gnt1, done0, done1, tx_start, busy;
   logic [9:0] tx_db;

   int checks   = 0;
   int failures = 0;
   int d0cnt    = 0;
   int d1cnt    = 0;
   int d0snap;

   lcd_cmd_arbiter #(
      .WAIT_SHORT(WS),
      .WAIT_LONG (WL)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .req0    (req0),
      .db0     (db0),
      .req1    (req1),
      .db1     (db1),
      .gnt0    (gnt0),
      .gnt1    (gnt1),
      .done0   (done0),
      .done1   (done1),
      .tx_start(tx_start),
      .tx_db   (tx_db),
      .tx_done (tx_done),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done0) d0cnt++;
      if (done1) d1cnt++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Request already raised; the next edge must grant the expected port.
   task automatic grant_chk(input int port, input logic [9:0] db, input string tag);
      step(1);
      chk1({tag, "_gnt0"}, gnt0, port == 0);
      chk1({tag, "_gnt1"}, gnt1, port == 1);
      chk10({tag, "_txdb"}, tx_db, db);
      chk1({tag, "_busy"}, busy, 1'b1);
      chk1({tag, "_nostart"}, tx_start, 1'b0);
   endtask

   // From the grant cycle: launch, tx_done 5 cycles after tx_start, then N hold-off cycles.
   task automatic finish_cmd(input int port, input logic [9:0] db, input int n, input string tag);
      step(1);
      chk1({tag, "_start"}, tx_start, 1'b1);
      chk1({tag, "_gnt_off"}, gnt0 | gnt1, 1'b0);
      step(1);
      chk1({tag, "_start_off"}, tx_start, 1'b0);
      step(3);
      tx_done = 1'b1;
      step(1);
      tx_done = 1'b0;
      step(n - 1);
      chk1({tag, "_done_early"}, port == 1 ? done1 : done0, 1'b0);
      chk1({tag, "_busy_hold"}, busy, 1'b1);
      chk10({tag, "_txdb_hold"}, tx_db, db);
      step(1);
      chk1({tag, "_done"}, port == 1 ? done1 : done0, 1'b1);
      chk1({tag, "_done_other"}, port == 1 ? done0 : done1, 1'b0);
      chk1({tag, "_busy_clr"}, busy, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0; tx_done = 1'b0;
      db0 = '0; db1 = '0;
      step(2);
      chk1("rst_busy", busy, 1'b0);
      chk10("rst_txdb", tx_db, 10'h000);
      chk1("rst_gnt", gnt0 | gnt1, 1'b0);
      chk1("rst_done", done0 | done1, 1'b0);
      chk1("rst_start", tx_start, 1'b0);
      reset = 1'b0;
      step(1);

      // Port 0 alone, short instruction
      db0 = 10'h028; req0 = 1'b1;
      grant_chk(0, 10'h028, "t1");
      req0 = 1'b0;
      finish_cmd(0, 10'h028, WS, "t1");
      step(1);
      chk1("t1_done_pulse", done0, 1'b0);
      chk_int("t1_no_done1", d1cnt, 0);

      // Port 1 Clear Display: long; db change after grant ignored
      db1 = 10'h001; req1 = 1'b1;
      grant_chk(1, 10'h001, "t2");
      req1 = 1'b0; db1 = 10'h3FF;
      finish_cmd(1, 10'h001, WL, "t2");

      // RW set: short despite opcode 0x03
      db1 = 10'h103; req1 = 1'b1;
      grant_chk(1, 10'h103, "t3");
      req1 = 1'b0;
      finish_cmd(1, 10'h103, WS, "t3");
      step(1);

      // Simultaneous requests held over two transactions
      db0 = 10'h00C; db1 = 10'h241; req0 = 1'b1; req1 = 1'b1;
      grant_chk(0, 10'h00C, "t4a");
      finish_cmd(0, 10'h00C, WS, "t4a");
`ifdef LCD_RR_ARB_EN
      grant_chk(1, 10'h241, "t4b");
      finish_cmd(1, 10'h241, WS, "t4b");
`else
      grant_chk(0, 10'h00C, "t4b");
      finish_cmd(0, 10'h00C, WS, "t4b");
`endif
      req0 = 1'b0; req1 = 1'b0;
      step(1);

      // Return Home on port 0; port 1 arrives mid-DELAY with a spurious tx_done
      db0 = 10'h003; req0 = 1'b1;
      grant_chk(0, 10'h003, "t5");
      req0 = 1'b0;
      step(1);
      step(3);
      tx_done = 1'b1;
      step(1);
      tx_done = 1'b0;
      step(5);
      db1 = 10'h241; req1 = 1'b1; tx_done = 1'b1;
      step(1);
      tx_done = 1'b0;
      step(WL - 7);
      chk1("t5_done_early", done0, 1'b0);
      chk1("t5_busy_hold", busy, 1'b1);
      chk1("t5_no_gnt1", gnt1, 1'b0);
      step(1);
      chk1("t5_done", done0, 1'b1);
      chk1("t5_gnt1_wait", gnt1, 1'b0);
      grant_chk(1, 10'h241, "t5b");
      req1 = 1'b0;
      finish_cmd(1, 10'h241, WS, "t5b");
      step(1);

      // Spurious tx_done in IDLE
      tx_done = 1'b1;
      step(1);
      tx_done = 1'b0;
      step(2);
      chk1("t6_idle_busy", busy, 1'b0);
      chk1("t6_idle_start", tx_start, 1'b0);
      db0 = 10'h006; req0 = 1'b1;
      grant_chk(0, 10'h006, "t6");
      req0 = 1'b0;
      finish_cmd(0, 10'h006, WS, "t6");
      step(1);

      // Reset in the middle of DELAY
      db0 = 10'h001; req0 = 1'b1;
      grant_chk(0, 10'h001, "t7");
      req0 = 1'b0;
      step(4);
      tx_done = 1'b1;
      step(1);
      tx_done = 1'b0;
      step(3);
      d0snap = d0cnt;
      reset = 1'b1;
      #1;
      chk1("t7_rst_busy", busy, 1'b0);
      chk10("t7_rst_txdb", tx_db, 10'h000);
      chk1("t7_rst_pulses", gnt0 | gnt1 | done0 | done1 | tx_start, 1'b0);
      step(1);
      reset = 1'b0;
      step(WL + 4);
      chk_int("t7_no_done", d0cnt, d0snap);
      chk1("t7_idle", busy, 1'b0);
      db1 = 10'h248; req1 = 1'b1;
      grant_chk(1, 10'h248, "t7b");
      req1 = 1'b0;
      finish_cmd(1, 10'h248, WS, "t7b");
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
